pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the RAPID-X five-stage pipeline. It watches the decode-stage operands, the instruction held in the ID/EX register, branch redirects and the data-memory busy line. From these it drives the hold, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It also sequences multi-cycle MUL/DIV operations occupying EX and keeps a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for load-use, redirect, memory freeze and multi-cycle MUL/DIV
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_mc_start,
  input  logic             i_ex_mc_is_div,
  input  logic             i_pc_load,
  input  logic             i_dmem_busy,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_hold,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_hold,
  output logic             o_ex_mem_bubble,
  output logic             o_mc_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_count
);
  localparam int MC_W = DIV_LATENCY > 2 ? $clog2(DIV_LATENCY) : 1;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;
  localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LATENCY - 2);
  localparam logic [MC_W-1:0] DIV_LOAD = MC_W'(DIV_LATENCY - 2);
  logic [0:0] state, state_nx;
  logic [MC_W-1:0] mc_cnt, mc_cnt_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic lu;
  assign lu = i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != 5'd0) &
              ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
               (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
  always_comb begin
    o_pc_stall = 1'b0;
    o_if_id_stall = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_hold = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_hold = 1'b0;
    o_ex_mem_bubble = 1'b0;
    o_mc_done = 1'b0;
    state_nx = state;
    mc_cnt_nx = mc_cnt;
    if (i_reset_n && state == RUN) begin
      if (i_dmem_busy) begin
        {o_pc_stall, o_if_id_stall, o_id_ex_hold, o_ex_mem_hold} = 4'b1111;
      end else if (i_pc_load) begin
        {o_if_id_flush, o_id_ex_flush} = 2'b11;
      end else if (i_ex_mc_start) begin
        {o_pc_stall, o_if_id_stall, o_id_ex_hold, o_ex_mem_bubble} = 4'b1111;
        mc_cnt_nx = i_ex_mc_is_div ? DIV_LOAD : MUL_LOAD;
        state_nx = MC_BUSY;
      end else if (lu) begin
        {o_pc_stall, o_if_id_stall, o_id_ex_flush} = 3'b111;
      end
    end else if (i_reset_n) begin
      // memory stalls overlap the busy countdown; only the done cycle waits for MEM
      if (mc_cnt != '0) begin
        {o_pc_stall, o_if_id_stall, o_id_ex_hold} = 3'b111;
        o_ex_mem_hold = i_dmem_busy;
        o_ex_mem_bubble = ~i_dmem_busy;
        mc_cnt_nx = mc_cnt - 1'b1;
      end else if (!i_dmem_busy) begin
        o_mc_done = 1'b1;
        state_nx = RUN;
      end else begin
        {o_pc_stall, o_if_id_stall, o_id_ex_hold, o_ex_mem_hold} = 4'b1111;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= RUN;
      mc_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      mc_cnt <= mc_cnt_nx;
      stall_cnt <= stall_cnt + CNT_W'(o_pc_stall);
    end
  end
  assign o_busy = i_reset_n & (state == MC_BUSY);
  assign o_stall_count = i_reset_n ? stall_cnt : '0;
endmodule
